hdmi_pll_supervisor: RTL and testbench
======================================

Name: hdmi_pll_supervisor

Overview:
Parametrised lock supervisor and reset sequencer for the HDMI TX PLL wrapper and its successors. Runs on the PLL reference clock. It pulses the PLL reset, waits for a stable lock with a timeout, and retries a bounded number of times. It then releases per-domain resets in staggered order and re-sequences on loss of lock or on request.

Parameters:
NUM_CLKS, 3, number of downstream clock domains; one chan_rst_o bit each; range 1..18
PLL_RST_CYCLES, 16, refclk cycles pll_rst_o is held high per attempt; >=1
LOCK_TIMEOUT, 1024, refclk cycles allowed in WAIT_LOCK before a retry; >=2
LOCK_STABLE_CYCLES, 256, consecutive synchronised-locked cycles required before release; >=1
STAGGER_CYCLES, 8, refclk cycles between successive channel reset releases; >=1
MAX_RETRIES, 3, timeouts tolerated before FAULT; >=0

Ports:
refclk  in  1  supervisor clock, PLL reference clock domain
rst  in  1  synchronous, active-high reset
pll_locked_i  in  1  PLL locked, asynchronous to refclk
restart_req_i  in  1  single-cycle request to re-sequence from scratch
pll_rst_o  out  1  reset to the PLL rst input
chan_rst_o  out  NUM_CLKS  per-domain reset, 1 = held in reset
ready_o  out  1  all channels released and lock held
fault_o  out  1  retries exhausted
retry_cnt_o  out  $clog2(MAX_RETRIES+1) (min 1)  timeouts in the current acquisition
state_o  out  3  encoded FSM state, for debug

Behaviour:
- Single clock domain: refclk. Reset is synchronous, active-high, named rst, matching the codebase PLL wrappers.
- pll_locked_i passes through a 2-flop synchroniser to give locked_s. Synchroniser latency is 2 cycles. All decisions use locked_s only.
- All outputs are registered.
- Reset values: pll_rst_o=1, chan_rst_o=all 1, ready_o=0, fault_o=0, retry_cnt_o=0, state=RESET_PLL, counters=0.
- State encoding: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4, FAULT=5.
- RESET_PLL: pll_rst_o=1 for exactly PLL_RST_CYCLES cycles, then go to WAIT_LOCK with the counter cleared.
- WAIT_LOCK: pll_rst_o=0.
  - If locked_s=1, go to STABLE.
  - Otherwise count up. At count LOCK_TIMEOUT-1: if retry_cnt==MAX_RETRIES, go to FAULT; else retry_cnt+1 and go to RESET_PLL.
- STABLE: count consecutive locked_s=1 cycles.
  - Any locked_s=0 returns to WAIT_LOCK with the timeout counter restarted. Glitch rejection does not consume a retry.
  - At count LOCK_STABLE_CYCLES, go to RELEASE with idx=0.
- RELEASE: every STAGGER_CYCLES cycles, clear chan_rst_o[idx] and increment idx.
  - Bit 0 is released on the first cycle of RELEASE, then bits 1..NUM_CLKS-1 at STAGGER_CYCLES intervals.
  - After the last bit is released, go to RUN. ready_o=1 on the following cycle.
- RUN: ready_o=1 and retry_cnt cleared to 0.
- Lock loss in STABLE is handled as above. Lock loss (locked_s=0) in RELEASE or RUN:
  - next cycle: chan_rst_o=all 1, ready_o=0;
  - go to RESET_PLL;
  - retry_cnt is unchanged in RELEASE and is 0 in RUN.
- FAULT: pll_rst_o=1, chan_rst_o=all 1, ready_o=0, fault_o=1. Held until rst or restart_req_i.
- restart_req_i in any state: next cycle state=RESET_PLL, retry_cnt=0, fault_o=0, chan_rst_o=all 1, ready_o=0.
- Priority, highest first: rst > restart_req_i > lock loss > timeout > normal progress.
- Counter width: $clog2 of the largest of the cycle parameters, +1. Counters saturate and never wrap. idx width is $clog2(NUM_CLKS)+1.
- chan_rst_o never deasserts unless state is RELEASE or RUN.

Optional Feature:
HDMI_PLL_SUP_LOSS_CNT_EN
- Defined: adds output lock_loss_cnt_o[15:0]. It increments once per lock-loss event in RELEASE or RUN, saturates at 16'hFFFF, and is cleared only by rst (not by restart_req_i).
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package hdmi_pll_sup_pkg holds the state enum (3-bit, encodings above) and a width helper function for counter sizing.
- One sub-module, hdmi_sync2: 2-flop synchroniser with reset value 0, instantiated for pll_locked_i.

Test Plan:
1. Locked rises 40 cycles after rst falls, defaults -> pll_rst_o high for cycles 1-16. Then chan_rst_o[0] clears 2+256 cycles after the lock edge, [1] 8 cycles later, [2] 8 cycles after that. ready_o=1 on the next cycle.
2. pll_locked_i held 0, LOCK_TIMEOUT=32, MAX_RETRIES=3 -> four RESET_PLL pulses of 16 cycles each, retry_cnt_o reaching 1,2,3, then fault_o=1 with outputs held in reset.
3. 3-cycle low glitch on locked during STABLE -> returns to WAIT_LOCK, retry_cnt_o stays 0, stable count restarts, release is delayed accordingly.
4. Lock drops in RUN -> 3 cycles later chan_rst_o=3'b111 and ready_o=0, pll_rst_o pulses, and the full sequence repeats. With the macro defined, lock_loss_cnt_o=1.
5. restart_req_i asserted in FAULT and mid-RELEASE -> next cycle state_o=0, fault_o=0, all chan_rst_o=1.
6. rst asserted mid-RUN -> next cycle every output equals its reset value.

Source files
------------

// File: rtl/hdmi_pll_sup_pkg.sv
// ---------------------------------------------------------------------------
// hdmi_pll_sup_pkg
// Shared definitions for the HDMI TX PLL lock supervisor:
//   - sup_state_t : 3-bit supervisor state, encodings exposed on state_o
//   - cnt_width   : width of the shared cycle counter (largest delay, +1 bit)
//   - retry_width : width of the retry counter (never less than 1 bit)
// ---------------------------------------------------------------------------
package hdmi_pll_sup_pkg;

   typedef enum logic [2:0] {
      ST_RESET_PLL = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RELEASE   = 3'd3,
      ST_RUN       = 3'd4,
      ST_FAULT     = 3'd5
   } sup_state_t;

   // One counter serves every timed phase, so it is sized for the longest one.
   // The extra bit leaves headroom so the saturation value is never a
   // legitimate terminal count.
   function automatic int cnt_width(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return $clog2(m) + 1;
   endfunction

   // MAX_RETRIES of zero would give a zero-width vector; keep one bit.
   function automatic int retry_width(input int max_retries);
      return (max_retries < 1) ? 1 : $clog2(max_retries + 1);
   endfunction

endpackage

// File: rtl/hdmi_sync2.sv
// ---------------------------------------------------------------------------
// hdmi_sync2
// Two-flop synchroniser for a single asynchronous level signal.
// Ports:
//   clk : destination clock
//   rst : synchronous active-high reset, clears both flops to 0
//   d   : asynchronous input
//   q   : synchronised output, two clk edges behind d
// ---------------------------------------------------------------------------
module hdmi_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // The first flop may go metastable; the second gives it a full cycle to
   // resolve before anything downstream looks at the value.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/hdmi_pll_supervisor.sv
// ---------------------------------------------------------------------------
// hdmi_pll_supervisor
// Lock supervisor and reset sequencer for the HDMI TX PLL. Pulses the PLL
// reset, waits for a stable lock (with timeout and bounded retries), then
// releases the downstream domain resets one at a time. Loss of lock or a
// restart request re-runs the whole sequence.
//
// Ports (all outputs registered, single clock refclk):
//   refclk          : PLL reference clock
//   rst             : synchronous active-high reset
//   pll_locked_i    : PLL lock indicator, asynchronous to refclk
//   restart_req_i   : single-cycle request to re-sequence from scratch
//   pll_rst_o       : reset to the PLL
//   chan_rst_o      : per-domain resets, 1 = held in reset
//   ready_o         : all domains released and lock held
//   fault_o         : retries exhausted
//   retry_cnt_o     : timeouts seen in the current acquisition
//   state_o         : encoded supervisor state for debug
//   lock_loss_cnt_o : (only with HDMI_PLL_SUP_LOSS_CNT_EN) saturating count
//                     of lock losses after release began; cleared by rst only
//
// Optional feature macro: HDMI_PLL_SUP_LOSS_CNT_EN
// ---------------------------------------------------------------------------
module hdmi_pll_supervisor
   import hdmi_pll_sup_pkg::*;
#(
   parameter int NUM_CLKS           = 3,
   parameter int PLL_RST_CYCLES     = 16,
   parameter int LOCK_TIMEOUT       = 1024,
   parameter int LOCK_STABLE_CYCLES = 256,
   parameter int STAGGER_CYCLES     = 8,
   parameter int MAX_RETRIES        = 3
) (
   input  logic                                   refclk,
   input  logic                                   rst,
   input  logic                                   pll_locked_i,
   input  logic                                   restart_req_i,
   output logic                                   pll_rst_o,
   output logic [NUM_CLKS-1:0]                    chan_rst_o,
   output logic                                   ready_o,
   output logic                                   fault_o,
   output logic [retry_width(MAX_RETRIES)-1:0]    retry_cnt_o,
   output logic [2:0]                             state_o
`ifdef HDMI_PLL_SUP_LOSS_CNT_EN
   ,
   output logic [15:0]                            lock_loss_cnt_o
`else
`endif
);

   localparam int CNT_W   = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT,
                                      LOCK_STABLE_CYCLES, STAGGER_CYCLES);
   localparam int RETRY_W = retry_width(MAX_RETRIES);
   localparam int IDX_W   = $clog2(NUM_CLKS) + 1;

   localparam logic [CNT_W-1:0]    RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]    TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]    STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]    STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
   localparam logic [RETRY_W-1:0]  RETRY_MAX    = RETRY_W'(MAX_RETRIES);
   localparam logic [IDX_W-1:0]    LAST_IDX     = IDX_W'(NUM_CLKS - 1);
   localparam logic [NUM_CLKS-1:0] ALL_RST      = '1;
   localparam logic [NUM_CLKS-1:0] CHAN_ONE     = NUM_CLKS'(1);

   sup_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic [IDX_W-1:0] idx;
   logic             locked_s;

   hdmi_sync2 u_lock_sync (
      .clk (refclk),
      .rst (rst),
      .d   (pll_locked_i),
      .q   (locked_s)
   );

   // Saturating increment: the counter may sit in a phase longer than its
   // terminal count (e.g. a very long stable window), but must never wrap.
   assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

   assign state_o = state;

   // Main sequencer. Priority is rst, then restart, then lock loss, then
   // timeout, then normal progress. Every output is a flop written here so
   // that downstream domains never see combinational glitches on resets.
   always_ff @(posedge refclk) begin
      if (rst) begin
         state       <= ST_RESET_PLL;
         cnt         <= '0;
         idx         <= '0;
         pll_rst_o   <= 1'b1;
         chan_rst_o  <= ALL_RST;
         ready_o     <= 1'b0;
         fault_o     <= 1'b0;
         retry_cnt_o <= '0;
      end else if (restart_req_i) begin
         state       <= ST_RESET_PLL;
         cnt         <= '0;
         idx         <= '0;
         pll_rst_o   <= 1'b1;
         chan_rst_o  <= ALL_RST;
         ready_o     <= 1'b0;
         fault_o     <= 1'b0;
         retry_cnt_o <= '0;
      end else begin
         unique case (state)
            ST_RESET_PLL: begin
               pll_rst_o  <= 1'b1;
               chan_rst_o <= ALL_RST;
               ready_o    <= 1'b0;
               if (cnt == RST_LAST) begin
                  state     <= ST_WAIT_LOCK;
                  cnt       <= '0;
                  pll_rst_o <= 1'b0;
               end else begin
                  cnt <= cnt_inc;
               end
            end

            ST_WAIT_LOCK: begin
               if (locked_s) begin
                  // The cycle that first sees lock counts as the first
                  // stable cycle, so a one-cycle window releases at once.
                  if (LOCK_STABLE_CYCLES == 1) begin
                     cnt        <= '0;
                     idx        <= IDX_W'(1);
                     chan_rst_o <= ALL_RST & ~CHAN_ONE;
                     if (NUM_CLKS == 1) begin
                        state       <= ST_RUN;
                        retry_cnt_o <= '0;
                     end else begin
                        state <= ST_RELEASE;
                     end
                  end else begin
                     state <= ST_STABLE;
                     cnt   <= CNT_W'(1);
                  end
               end else if (cnt == TIMEOUT_LAST) begin
                  cnt       <= '0;
                  pll_rst_o <= 1'b1;
                  if (retry_cnt_o == RETRY_MAX) begin
                     state   <= ST_FAULT;
                     fault_o <= 1'b1;
                  end else begin
                     state       <= ST_RESET_PLL;
                     retry_cnt_o <= retry_cnt_o + RETRY_W'(1);
                  end
               end else begin
                  cnt <= cnt_inc;
               end
            end

            ST_STABLE: begin
               // A glitch restarts the timeout window but is not a retry.
               if (!locked_s) begin
                  state <= ST_WAIT_LOCK;
                  cnt   <= '0;
               end else if (cnt >= STABLE_LAST) begin
                  cnt        <= '0;
                  idx        <= IDX_W'(1);
                  chan_rst_o <= ALL_RST & ~CHAN_ONE;
                  if (NUM_CLKS == 1) begin
                     state       <= ST_RUN;
                     retry_cnt_o <= '0;
                  end else begin
                     state <= ST_RELEASE;
                  end
               end else begin
                  cnt <= cnt_inc;
               end
            end

            ST_RELEASE: begin
               if (!locked_s) begin
                  state      <= ST_RESET_PLL;
                  cnt        <= '0;
                  idx        <= '0;
                  pll_rst_o  <= 1'b1;
                  chan_rst_o <= ALL_RST;
                  ready_o    <= 1'b0;
               end else if (cnt == STAGGER_LAST) begin
                  cnt        <= '0;
                  idx        <= idx + IDX_W'(1);
                  chan_rst_o <= chan_rst_o & ~(CHAN_ONE << idx);
                  if (idx == LAST_IDX) begin
                     state       <= ST_RUN;
                     retry_cnt_o <= '0;
                  end
               end else begin
                  cnt <= cnt_inc;
               end
            end

            ST_RUN: begin
               if (!locked_s) begin
                  state       <= ST_RESET_PLL;
                  cnt         <= '0;
                  idx         <= '0;
                  pll_rst_o   <= 1'b1;
                  chan_rst_o  <= ALL_RST;
                  ready_o     <= 1'b0;
                  retry_cnt_o <= '0;
               end else begin
                  ready_o     <= 1'b1;
                  retry_cnt_o <= '0;
               end
            end

            ST_FAULT: begin
               pll_rst_o  <= 1'b1;
               chan_rst_o <= ALL_RST;
               ready_o    <= 1'b0;
               fault_o    <= 1'b1;
            end

            default: begin
               state      <= ST_RESET_PLL;
               cnt        <= '0;
               idx        <= '0;
               pll_rst_o  <= 1'b1;
               chan_rst_o <= ALL_RST;
               ready_o    <= 1'b0;
            end
         endcase
      end
   end

`ifdef HDMI_PLL_SUP_LOSS_CNT_EN
   logic lock_loss_evt;

   // A loss only counts when the sequencer actually acts on it, so a
   // simultaneous restart request masks it.
   assign lock_loss_evt = !restart_req_i && !locked_s &&
                          ((state == ST_RELEASE) || (state == ST_RUN));

   // Field-health counter: survives restarts so it accumulates across
   // re-sequences, and sticks at all-ones rather than wrapping.
   always_ff @(posedge refclk) begin
      if (rst) begin
         lock_loss_cnt_o <= '0;
      end else if (lock_loss_evt && (lock_loss_cnt_o != 16'hFFFF)) begin
         lock_loss_cnt_o <= lock_loss_cnt_o + 16'd1;
      end
   end
`else
   // Without the loss counter there is no extra state to keep.
`endif

endmodule

// File: tb/tb_hdmi_pll_supervisor.sv
// ---------------------------------------------------------------------------
// tb_hdmi_pll_supervisor
// Self-checking bench for hdmi_pll_supervisor. A timestamp-based reference
// model predicts every output each cycle from the sequencing rules; a few
// directed timing measurements are also compared against closed-form values.
// ---------------------------------------------------------------------------
module tb_hdmi_pll_supervisor;

   localparam int NUM_CLKS           = 3;
   localparam int PLL_RST_CYCLES     = 16;
   localparam int LOCK_TIMEOUT       = 32;
   localparam int LOCK_STABLE_CYCLES = 256;
   localparam int STAGGER_CYCLES     = 8;
   localparam int MAX_RETRIES        = 3;

   logic                refclk = 1'b0;
   logic                rst = 1'b1;
   logic                pll_locked_i = 1'b0;
   logic                restart_req_i = 1'b0;
   logic                pll_rst_o;
   logic [NUM_CLKS-1:0] chan_rst_o;
   logic                ready_o;
   logic                fault_o;
   logic [1:0]          retry_cnt_o;
   logic [2:0]          state_o;
`ifdef HDMI_PLL_SUP_LOSS_CNT_EN
   logic [15:0]         lock_loss_cnt_o;
`endif

   int checks = 0;
   int errors = 0;

   hdmi_pll_supervisor #(
      .NUM_CLKS           (NUM_CLKS),
      .PLL_RST_CYCLES     (PLL_RST_CYCLES),
      .LOCK_TIMEOUT       (LOCK_TIMEOUT),
      .LOCK_STABLE_CYCLES (LOCK_STABLE_CYCLES),
      .STAGGER_CYCLES     (STAGGER_CYCLES),
      .MAX_RETRIES        (MAX_RETRIES)
   ) dut (
      .refclk          (refclk),
      .rst             (rst),
      .pll_locked_i    (pll_locked_i),
      .restart_req_i   (restart_req_i),
      .pll_rst_o       (pll_rst_o),
      .chan_rst_o      (chan_rst_o),
      .ready_o         (ready_o),
      .fault_o         (fault_o),
      .retry_cnt_o     (retry_cnt_o),
      .state_o         (state_o)
`ifdef HDMI_PLL_SUP_LOSS_CNT_EN
      ,
      .lock_loss_cnt_o (lock_loss_cnt_o)
`endif
   );

   // Free-running reference clock, 10 time units per period.
   always #5 refclk = ~refclk;

   // Reference model. Rather than counters it keeps the edge number at
   // which each phase began and derives outputs from elapsed time.
   typedef enum int {P_PULSE, P_ACQUIRE, P_SEQUENCE, P_FAULT} phase_t;

   phase_t m_phase   = P_PULSE;
   int     m_edge    = 0;
   int     m_t_pulse = 0;
   int     m_t_wait  = 0;
   int     m_t_rel   = 0;
   int     m_run     = 0;
   int     m_retries = 0;
   int     m_losses  = 0;
   logic   m_s1      = 1'b0;
   logic   m_s2      = 1'b0;

   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%0h expected=%0h (edge %0d)", tag, got, exp, m_edge);
      end
   endtask

   // Advance the model by one clock edge given the inputs present at it.
   task automatic modelStep(input logic r, input logic lk, input logic rq);
      logic ls;
      m_edge++;
      ls = m_s2;
      if (r) begin
         m_s1 = 1'b0;
         m_s2 = 1'b0;
      end else begin
         m_s2 = m_s1;
         m_s1 = lk;
      end
      if (r) begin
         m_phase = P_PULSE; m_t_pulse = m_edge; m_retries = 0; m_losses = 0;
      end else if (rq) begin
         m_phase = P_PULSE; m_t_pulse = m_edge; m_retries = 0;
      end else begin
         case (m_phase)
            P_PULSE: begin
               if (m_edge - m_t_pulse == PLL_RST_CYCLES) begin
                  m_phase = P_ACQUIRE; m_t_wait = m_edge; m_run = 0;
               end
            end
            P_ACQUIRE: begin
               if (ls) begin
                  m_run++;
                  if (m_run == LOCK_STABLE_CYCLES) begin
                     m_phase = P_SEQUENCE; m_t_rel = m_edge;
                  end
               end else if (m_run > 0) begin
                  m_run = 0; m_t_wait = m_edge;
               end else if (m_edge - m_t_wait == LOCK_TIMEOUT) begin
                  if (m_retries == MAX_RETRIES) begin
                     m_phase = P_FAULT;
                  end else begin
                     m_retries++; m_phase = P_PULSE; m_t_pulse = m_edge;
                  end
               end
            end
            P_SEQUENCE: begin
               if (!ls) begin
                  if (m_losses < 65535) m_losses++;
                  m_phase = P_PULSE; m_t_pulse = m_edge;
               end
            end
            default: ;
         endcase
      end
      if (m_phase == P_SEQUENCE &&
          m_edge >= m_t_rel + (NUM_CLKS - 1) * STAGGER_CYCLES)
         m_retries = 0;
   endtask

   // Drive one cycle of inputs on the falling edge, step the model on the
   // rising edge, then compare every output a little after that edge.
   task automatic applyStimulus(input logic r, input logic lk, input logic rq);
      logic [NUM_CLKS-1:0] exp_chan;
      int                  all_out_edge;
      int                  exp_state;
      @(negedge refclk);
      rst = r; pll_locked_i = lk; restart_req_i = rq;
      @(posedge refclk);
      modelStep(r, lk, rq);
      #1;
      all_out_edge = m_t_rel + (NUM_CLKS - 1) * STAGGER_CYCLES;
      exp_chan = '1;
      if (m_phase == P_SEQUENCE)
         for (int i = 0; i < NUM_CLKS; i++)
            if (m_edge >= m_t_rel + i * STAGGER_CYCLES) exp_chan[i] = 1'b0;
      case (m_phase)
         P_PULSE:    exp_state = 0;
         P_ACQUIRE:  exp_state = (m_run > 0) ? 2 : 1;
         P_SEQUENCE: exp_state = (m_edge >= all_out_edge) ? 4 : 3;
         default:    exp_state = 5;
      endcase
      checkOutput("state", 32'(state_o), exp_state);
      checkOutput("pll_rst", 32'(pll_rst_o),
                  32'((m_phase == P_PULSE) || (m_phase == P_FAULT)));
      checkOutput("chan_rst", 32'(chan_rst_o), 32'(exp_chan));
      checkOutput("ready", 32'(ready_o),
                  32'((m_phase == P_SEQUENCE) && (m_edge >= all_out_edge + 1)));
      checkOutput("fault", 32'(fault_o), 32'(m_phase == P_FAULT));
      checkOutput("retry_cnt", 32'(retry_cnt_o), m_retries);
`ifdef HDMI_PLL_SUP_LOSS_CNT_EN
      checkOutput("lock_loss_cnt", 32'(lock_loss_cnt_o), m_losses);
`endif
   endtask

   task automatic holdLock(input logic lk, input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, lk, 1'b0);
   endtask

   initial begin
      int pll_high;
      int rel0, rel1, rel2, rdy;
      int exp_rel0;

      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);

      // Nominal bring-up: lock rises 40 cycles after reset release. Iteration
      // 0 is the last reset edge; lock is first sampled at edge 40, seen by
      // the sequencer at edge 42, which is the first of the stable cycles.
      pll_high = 0; rel0 = -1; rel1 = -1; rel2 = -1; rdy = -1;
      for (int k = 0; k <= 330; k++) begin
         applyStimulus(k == 0, k >= 40, 1'b0);
         if (pll_rst_o) pll_high++;
         if (rel0 < 0 && !chan_rst_o[0]) rel0 = k;
         if (rel1 < 0 && !chan_rst_o[1]) rel1 = k;
         if (rel2 < 0 && !chan_rst_o[2]) rel2 = k;
         if (rdy < 0 && ready_o) rdy = k;
      end
      exp_rel0 = 40 + 2 + LOCK_STABLE_CYCLES - 1;
      checkOutput("pll_pulse_len", pll_high, PLL_RST_CYCLES);
      checkOutput("chan0_release", rel0, exp_rel0);
      checkOutput("chan1_release", rel1, exp_rel0 + STAGGER_CYCLES);
      checkOutput("chan2_release", rel2, exp_rel0 + 2 * STAGGER_CYCLES);
      checkOutput("ready_rise", rdy, exp_rel0 + 2 * STAGGER_CYCLES + 1);

      // Lock drop in RUN, then full re-acquisition.
      holdLock(1'b0, $urandom_range(4, 1));
      holdLock(1'b1, 320);

      // Reset in the middle of RUN, then re-acquire.
      applyStimulus(1'b1, 1'b1, 1'b0);
      holdLock(1'b1, 320);

      // Restart request while channels are being released.
      applyStimulus(1'b0, 1'b1, 1'b1);
      holdLock(1'b1, 275 + $urandom_range(14, 0));
      applyStimulus(1'b0, 1'b1, 1'b1);
      holdLock(1'b1, 10);

      // No lock at all: every retry times out and the supervisor faults.
      applyStimulus(1'b0, 1'b0, 1'b1);
      holdLock(1'b0, 4 * (PLL_RST_CYCLES + LOCK_TIMEOUT) + 20);

      // Restart out of FAULT, then a short glitch during the stable window.
      applyStimulus(1'b0, 1'b0, 1'b1);
      holdLock(1'b0, $urandom_range(10, 0));
      holdLock(1'b1, $urandom_range(150, 30));
      holdLock(1'b0, 3);
      holdLock(1'b1, 300);

      // Random soak: lock level runs of random length with rare restarts
      // and resets.
      for (int seg = 0; seg < 40; seg++) begin
         logic lvl;
         int   len;
         lvl = 1'($urandom_range(1, 0));
         len = $urandom_range(300, 1);
         for (int c = 0; c < len; c++)
            applyStimulus($urandom_range(999, 0) == 0, lvl,
                          $urandom_range(199, 0) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
